// File: rtl/icache_pkg.sv
// icache_pkg: shared default geometry and FSM state encoding for the instruction cache.
package icache_pkg;
    localparam int ICACHE_INDEX_BITS = 8;
    typedef enum logic {IDLE = 1'b0, MISS = 1'b1} icache_state_e;
endpackage

// File: rtl/icache_array.sv
// icache_array: valid/tag/data line storage with a combinational read port and one synchronous write port.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output logic [31:0]           rd_data_o,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  logic [31:0]           wr_data_i
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) valid_q <= '0;
        else if (we_i) valid_q[wr_idx_i] <= 1'b1;
    end

    // Tag and data carry no reset; a line is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped one-word-per-line instruction cache with a single outstanding miss.
// Define ICACHE_BYPASS_EN to forward the fill word to the fetch unit in the mem_enable cycle.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_valid,
    input  logic [31:0] if_addr,
    input  logic        if_clear,
    output logic        if_hit,
    output logic [31:0] if_inst,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    input  logic        mem_enable,
    input  logic [31:0] mem_din
);
    icache_state_e state_q, state_d;
    logic [29:0]   miss_addr_q, miss_addr_d;
    logic          mem_valid_q, mem_valid_d;
    logic          rd_valid, lookup_hit, bypass, we;
    logic [TAG_BITS-1:0] rd_tag;
    logic [31:0]   rd_data;

    icache_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (if_addr[INDEX_BITS+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .we_i       (we),
        .wr_idx_i   (miss_addr_q[INDEX_BITS-1:0]),
        .wr_tag_i   (miss_addr_q[29 -: TAG_BITS]),
        .wr_data_i  (mem_din)
    );

    assign lookup_hit = rd_valid & (rd_tag == if_addr[31 -: TAG_BITS]);

`ifdef ICACHE_BYPASS_EN
    assign bypass = rdy & (state_q == MISS) & mem_enable & if_valid & ~if_clear
                  & (if_addr[31:2] == miss_addr_q);
`else
    assign bypass = 1'b0;
`endif

    assign if_hit    = (rdy & if_valid & (state_q == IDLE) & lookup_hit) | bypass;
    assign if_inst   = bypass ? mem_din : rd_data;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = {miss_addr_q, 2'b00};

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        mem_valid_d = mem_valid_q;
        we          = 1'b0;
        if (rdy) begin
            if (if_clear) begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
            end else if (state_q == IDLE && if_valid && !lookup_hit) begin
                state_d     = MISS;
                miss_addr_d = if_addr[31:2];
                mem_valid_d = 1'b1;
            end else if (state_q == MISS && mem_enable) begin
                state_d     = IDLE;
                mem_valid_d = 1'b0;
                we          = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            mem_valid_q <= mem_valid_d;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed plus randomized checks of icache against a word-address reference model.
module tb_icache;
    localparam int IB    = 8;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
    logic        if_valid = 1'b0, if_clear = 1'b0, mem_enable = 1'b0;
    logic [31:0] if_addr = '0, mem_din = '0;
    logic        if_hit, mem_valid;
    logic [31:0] if_inst, mem_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: each line remembers which word address it holds.
    logic [29:0] m_line [int];
    logic [31:0] m_word [int];
    bit          busy = 0;
    logic [29:0] pend = '0;

    icache #(.INDEX_BITS(IB)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .if_valid(if_valid), .if_addr(if_addr),
        .if_clear(if_clear), .if_hit(if_hit), .if_inst(if_inst), .mem_valid(mem_valid),
        .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_din(mem_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", t, o, e);
        end
    endtask

    task automatic step(input string t, input bit v, input logic [31:0] a, input bit clr,
                        input bit r, input bit me, input logic [31:0] d);
        int          i;
        logic [29:0] w;
        bit          present, e_byp, e_hit;
        @(negedge clk);
        if_valid = v; if_addr = a; if_clear = clr; rdy = r; mem_enable = me; mem_din = d;
        #1;
        w       = a[31:2];
        i       = int'(w % LINES);
        present = m_line.exists(i) && m_line[i] == w;
        e_byp   = 0;
`ifdef ICACHE_BYPASS_EN
        e_byp   = r && busy && me && v && !clr && w == pend;
`endif
        e_hit   = (r && v && !busy && present) || e_byp;
        chk({t, ".hit"}, {31'b0, if_hit}, {31'b0, e_hit});
        chk({t, ".mem_valid"}, {31'b0, mem_valid}, {31'b0, busy});
        chk({t, ".mem_addr"}, mem_addr, {pend, 2'b00});
        if (e_hit) chk({t, ".inst"}, if_inst, e_byp ? d : m_word[i]);
        if (r) begin
            if (clr) busy = 0;
            else if (!busy && v && !present) begin
                busy = 1;
                pend = w;
            end else if (busy && me) begin
                m_line[int'(pend % LINES)] = pend;
                m_word[int'(pend % LINES)] = d;
                busy = 0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; if_valid = 0; if_clear = 0; mem_enable = 1; mem_din = 32'hBAD0BAD0; rdy = 1;
        @(negedge clk);
        rst = 0; mem_enable = 0;
        m_line.delete(); m_word.delete();
        busy = 0; pend = '0;
    endtask

    task automatic miss_fill(input string t, input logic [31:0] a, input logic [31:0] d);
        step(t, 1, a, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) step(t, 1, a, 0, 1, 0, 0);
        step(t, 1, a, 0, 1, 1, d);
        step(t, 1, a, 0, 1, 0, 0);
    endtask

    initial begin
        logic [31:0] pool [8];
        logic [31:0] a;
        pool = '{32'h0, 32'h400, 32'h4, 32'h104, 32'h8, 32'h800, 32'h10, 32'h3fc};
        do_reset();
        step("reset", 0, 0, 0, 1, 0, 0);
        miss_fill("first", 32'h0, 32'h00000013);
        chk("first.inst_const", if_inst, 32'h00000013);
        miss_fill("evict", 32'h400, 32'h12345678);
        miss_fill("refetch", 32'h0, 32'h00000093);
        step("clr", 1, 32'h104, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) step("clr", 1, 32'h104, 0, 1, 0, 0);
        step("clr.fill", 1, 32'h104, 1, 1, 1, 32'hDEADBEEF);
        step("clr.after", 1, 32'h104, 0, 1, 0, 0);
        chk("clr.after_mv", {31'b0, mem_valid}, 32'h0);
        for (int k = 0; k < 4; k++) step("clr.re", 1, 32'h104, 0, 1, 0, 0);
        step("clr.re", 1, 32'h104, 0, 1, 1, 32'hCAFEF00D);
        step("clr.re", 1, 32'h104, 0, 1, 0, 0);
        step("rdy", 1, 32'h200, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) step("rdy.low", 1, 32'h200, 0, 0, 1, 32'h55555555);
        chk("rdy.low_addr", mem_addr, 32'h200);
        step("rdy.back", 1, 32'h200, 0, 1, 0, 0);
        step("rdy.fill", 1, 32'h200, 0, 1, 1, 32'h0BADF00D);
        step("rdy.hit", 1, 32'h200, 0, 1, 0, 0);
        step("rdy.lowhit", 1, 32'h200, 0, 0, 0, 0);
        miss_fill("byp", 32'h8, 32'h00A00093);
        step("rstmid", 1, 32'h10, 0, 1, 0, 0);
        step("rstmid", 1, 32'h10, 0, 1, 0, 0);
        do_reset();
        step("rstmid.after", 1, 32'h0, 0, 1, 0, 0);
        step("rstmid.mv", 0, 32'h0, 0, 1, 1, 32'h13);
        step("addr3", 1, 32'h3, 0, 1, 0, 0);
        step("addr3.req", 1, 32'h3, 0, 1, 0, 0);
        chk("addr3.mem_addr", mem_addr, 32'h0);
        step("addr3.fill", 1, 32'h3, 0, 1, 1, 32'h11111111);
        step("addr3.hit", 1, 32'h0, 0, 1, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0000_0ffc) | $urandom_range(0, 3)
                                            : pool[$urandom_range(0, 7)] | $urandom_range(0, 3);
            step("rand", $urandom_range(0, 4) != 0, a, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 7) != 0, busy && $urandom_range(0, 3) == 0, $urandom);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller. Lookup is combinational. On a miss, the cache issues a single word request on the controller's instruction port and holds it until the controller returns the word. The fetch unit sees a hit on the cycle after the fill.

## Interface
- `INDEX_BITS`, default 8: line-index width. The cache has 2^INDEX_BITS lines of 32 bits each.
- `TAG_BITS`, default 30-INDEX_BITS: tag width, taken from addr[31:2+INDEX_BITS].

- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `rdy`  in  1: global ready. When low, the cache freezes.
- `if_valid`  in  1: fetch unit requests the instruction at `if_addr`.
- `if_addr`  in  32: fetch address. Bits [1:0] are ignored.
- `if_clear`  in  1: flush from the ROB. Aborts any outstanding miss.
- `if_hit`  out  1: `if_inst` is valid this cycle for `if_addr`.
- `if_inst`  out  32: instruction word.
- `mem_valid`  out  1: request to the memory controller's instruction port.
- `mem_addr`  out  32: word-aligned fill address.
- `mem_enable`  in  1: one-cycle pulse; `mem_din` is valid this cycle.
- `mem_din`  in  32: fill word, little-endian assembled.

## Operation
- Storage:
  - `valid[2^INDEX_BITS]`
  - `tag[2^INDEX_BITS]`
  - `data[2^INDEX_BITS]`
  - index = addr[INDEX_BITS+1:2]
- Hit logic, combinational: `if_hit` = `if_valid` & valid[idx] & (tag[idx]==addr tag) & (state==IDLE). `if_inst` = data[idx] regardless of hit.
- States:
  - **IDLE**: when `if_valid` & ~hit & ~`if_clear`:
    - latch {if_addr[31:2],2'b00} into `miss_addr` and `mem_addr`
    - set `mem_valid` = 1
    - go to MISS
  - **MISS**: `mem_valid` held high and `mem_addr` held stable.
    - On `mem_enable`:
      - write valid/tag/data at the `miss_addr` index
      - clear `mem_valid`
      - go to IDLE
    - Dropping `if_valid` without `if_clear` does not abort the miss; the fill completes.
- `if_clear` takes priority in any state:
  - next state IDLE, `mem_valid` cleared
  - no array write, even if `mem_enable` arrives in the same cycle
  - cache contents are retained
- The memory controller aborts its in-flight fetch when `mem_valid` drops. The cache never re-raises `mem_valid` in the cycle it drops it.
- `rdy` low:
  - state, `mem_valid`, `mem_addr` and the arrays are held
  - `if_hit` forced to 0
  - `mem_enable` ignored
- Reset:
  - state IDLE, all valid bits 0, `mem_valid` 0, `mem_addr` 0
  - `if_hit` is therefore 0
  - tag and data arrays are not reset
- Reset mid-miss: `mem_valid` drops on the reset edge and the fill is discarded.

## Timing
- Hit: zero-cycle latency. `if_hit` is in the same cycle as `if_valid`/`if_addr`.
- Miss:
  - `mem_valid` rises at edge E+1 after the miss cycle E.
  - The controller takes 1 cycle of address issue plus 4 byte cycles, and `mem_enable` pulses in cycle F.
  - The array is written at edge F+1 and the state returns to IDLE.
  - `if_hit` for the same address is in cycle F+1.
- `mem_valid` is registered and is still high during the `mem_enable` cycle. The controller may begin a redundant fetch, which is aborted when `mem_valid` falls at F+1.
- Back-to-back misses: the next `mem_valid` rises no earlier than F+2.
- Fill to an index whose line is valid with a different tag: overwrite, no writeback.

## Configuration
- `ICACHE_BYPASS_EN`:
  - **Defined**: in the `mem_enable` cycle, if `if_valid` is set and `if_addr[31:2]` equals `miss_addr[31:2]`, then `if_hit` = 1 and `if_inst` = `mem_din`. This saves one cycle per miss. `if_clear` in the same cycle suppresses the bypass.
  - **Undefined**: `if_hit` is never asserted in MISS; the first hit is in cycle F+1.

## Structure
- `ICACHE_INDEX_BITS` default and the IDLE/MISS state encodings go in `defines.v`, alongside the existing `` `True``/`` `False``.
- One sub-module, `icache_array`, is natural:
  - valid/tag/data storage
  - combinational read port
  - synchronous single write port with reset of the valid bits
- The FSM, hit compare and bypass stay in `icache`.

## Test plan
- Reset, then `if_valid`=1 with `if_addr`=0x00000000 → `if_hit`=0, `mem_valid`=1 with `mem_addr`=0 next cycle. Return `mem_din`=0x00000013 → one cycle later `if_hit`=1, `if_inst`=0x00000013.
- Addresses 0x0 then 0x400 (same index, INDEX_BITS=8) → second request misses and evicts. Re-fetching 0x0 misses again.
- Miss on 0x104, assert `if_clear` in the same cycle as `mem_enable` with `mem_din`=0xDEADBEEF → no write, `mem_valid` 0 next cycle, 0x104 still misses.
- `rdy` low for 3 cycles during MISS → `mem_valid`/`mem_addr` unchanged, `if_hit`=0. Fill completes after `rdy` returns.
- `ICACHE_BYPASS_EN` defined, miss on 0x8 with `if_valid` held → `if_hit`=1 and `if_inst`=`mem_din` in the `mem_enable` cycle. Without the macro, the hit comes one cycle later.
- `if_addr`=0x3 → treated as 0x0, and `mem_addr` is 0x0.
